uart_frame_decoder: RTL and testbench

- Consumes the byte stream from the UART receiver (one-cycle data-valid strobe plus byte).
- Frames the stream as SYNC, ADDR, LEN, PAYLOAD[LEN], CHK and buffers the payload internally.
- After a good checksum, replays the payload to downstream register/command logic over a valid/ready handshake.
- Malformed, timed-out or overrun frames are discarded and reported with an error code.

---
 rtl/uart_frame_decoder.sv | 173 +++++++++++++++++
 tb/tb_uart_frame_decoder.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_decoder.sv
// Frames a UART byte stream as SYNC, ADDR, LEN, PAYLOAD[LEN], CHK, buffers the payload,
// and replays it over valid/ready once the XOR checksum matches.
module uart_frame_decoder #(
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter int         MAX_LEN      = 16,
    parameter int         TIMEOUT_CLKS = 20000
) (
    input  logic       i_Clock,
    input  logic       i_Reset_n,
    input  logic       i_Rx_DV,
    input  logic [7:0] i_Rx_Byte,
    output logic [7:0] o_Addr,
    output logic [7:0] o_Len,
    output logic [7:0] o_Data,
    output logic       o_Data_Valid,
    input  logic       i_Data_Ready,
    output logic       o_Data_Last,
    output logic       o_Frame_OK,
    output logic       o_Frame_Err,
    output logic [1:0] o_Err_Code
);

    localparam logic [2:0] S_SYNC    = 3'd0;
    localparam logic [2:0] S_ADDR    = 3'd1;
    localparam logic [2:0] S_LEN     = 3'd2;
    localparam logic [2:0] S_PAYLOAD = 3'd3;
    localparam logic [2:0] S_CHK     = 3'd4;
    localparam logic [2:0] S_OUT     = 3'd5;

    localparam logic [1:0] ERR_CHK     = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_OVERRUN = 2'd3;

    localparam int TW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CLKS - 1);
    localparam logic [TW-1:0] TIMER_ONE  = TW'(1);

    logic [2:0]    state;
    logic [7:0]    chk;
    logic [7:0]    idx;
    logic [7:0]    addr_q;
    logic [7:0]    len_q;
    logic [TW-1:0] timer;
    logic [7:0]    mem [0:(1 << AW) - 1];

    logic timed;
    logic timeout;
    logic out_valid;
    logic is_last;
    logic handshake;

    assign timed     = (state == S_ADDR) || (state == S_LEN) ||
                       (state == S_PAYLOAD) || (state == S_CHK);
    // An arriving byte always beats the timeout on the same cycle.
    assign timeout   = timed && !i_Rx_DV && (timer == TIMER_LAST);
    assign out_valid = (state == S_OUT);
    assign is_last   = (idx == len_q - 8'd1);
    assign handshake = out_valid && i_Data_Ready;

    assign o_Data_Valid = out_valid;
    assign o_Data       = out_valid ? mem[idx[AW-1:0]] : 8'h00;
    assign o_Data_Last  = out_valid && is_last;

    // NOTE: the payload buffer has no reset; every entry is written before it is replayed.
    always_ff @(posedge i_Clock) begin
        if (state == S_PAYLOAD && i_Rx_DV) begin
            mem[idx[AW-1:0]] <= i_Rx_Byte;
        end
    end

    // NOTE: all state updates are non-blocking so every branch sees pre-edge values.
    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) begin
            state       <= S_SYNC;
            chk         <= 8'h00;
            idx         <= 8'h00;
            timer       <= '0;
            addr_q      <= 8'h00;
            len_q       <= 8'h00;
            o_Addr      <= 8'h00;
            o_Len       <= 8'h00;
            o_Frame_OK  <= 1'b0;
            o_Frame_Err <= 1'b0;
            o_Err_Code  <= ERR_CHK;
        end else begin
            o_Frame_OK  <= 1'b0;
            o_Frame_Err <= 1'b0;

            if (!timed || i_Rx_DV || timeout) begin
                timer <= '0;
            end else begin
                timer <= timer + TIMER_ONE;
            end

            if (timeout) begin
                o_Frame_Err <= 1'b1;
                o_Err_Code  <= ERR_TIMEOUT;
                state       <= S_SYNC;
            end else begin
                case (state)
                    S_SYNC: begin
                        if (i_Rx_DV && i_Rx_Byte == SYNC_BYTE) begin
                            chk   <= 8'h00;
                            state <= S_ADDR;
                        end
                    end
                    S_ADDR: begin
                        if (i_Rx_DV) begin
                            addr_q <= i_Rx_Byte;
                            chk    <= chk ^ i_Rx_Byte;
                            state  <= S_LEN;
                        end
                    end
                    S_LEN: begin
                        if (i_Rx_DV) begin
                            if (i_Rx_Byte == 8'h00 || i_Rx_Byte > 8'(MAX_LEN)) begin
                                o_Frame_Err <= 1'b1;
                                o_Err_Code  <= ERR_LEN;
                                state       <= S_SYNC;
                            end else begin
                                len_q <= i_Rx_Byte;
                                chk   <= chk ^ i_Rx_Byte;
                                idx   <= 8'h00;
                                state <= S_PAYLOAD;
                            end
                        end
                    end
                    S_PAYLOAD: begin
                        if (i_Rx_DV) begin
                            chk <= chk ^ i_Rx_Byte;
                            idx <= idx + 8'd1;
                            if (is_last) begin
                                state <= S_CHK;
                            end
                        end
                    end
                    S_CHK: begin
                        if (i_Rx_DV) begin
                            if (i_Rx_Byte == chk) begin
                                o_Addr     <= addr_q;
                                o_Len      <= len_q;
                                o_Frame_OK <= 1'b1;
                                idx        <= 8'h00;
                                state      <= S_OUT;
                            end else begin
                                o_Frame_Err <= 1'b1;
                                o_Err_Code  <= ERR_CHK;
                                state       <= S_SYNC;
                            end
                        end
                    end
                    S_OUT: begin
                        // Bytes arriving during replay are dropped; replay carries on.
                        if (i_Rx_DV) begin
                            o_Frame_Err <= 1'b1;
                            o_Err_Code  <= ERR_OVERRUN;
                        end
                        if (handshake) begin
                            idx <= idx + 8'd1;
                            if (is_last) begin
                                state <= S_SYNC;
                            end
                        end
                    end
                    default: state <= S_SYNC;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Self-checking bench for uart_frame_decoder: directed frames plus randomized frames,
// checked against a frame-level expectation model (event queue and payload queue).
module tb_uart_frame_decoder;

    localparam int         T    = 40;
    localparam int         ML   = 16;
    localparam logic [7:0] SYNC = 8'hA5;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       rx_dv   = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       rdy     = 1'b1;
    logic [7:0] o_addr, o_len, o_data;
    logic       o_valid, o_last, o_ok, o_err;
    logic [1:0] o_code;

    uart_frame_decoder #(.SYNC_BYTE(SYNC), .MAX_LEN(ML), .TIMEOUT_CLKS(T)) dut (
        .i_Clock(clk), .i_Reset_n(rst_n), .i_Rx_DV(rx_dv), .i_Rx_Byte(rx_byte),
        .o_Addr(o_addr), .o_Len(o_len), .o_Data(o_data), .o_Data_Valid(o_valid),
        .i_Data_Ready(rdy), .o_Data_Last(o_last), .o_Frame_OK(o_ok),
        .o_Frame_Err(o_err), .o_Err_Code(o_code)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { bit is_ok; logic [7:0] addr; logic [7:0] len; logic [1:0] code; } ev_t;
    typedef struct { logic [7:0] data; bit last; } db_t;

    ev_t        exp_ev[$];
    db_t        exp_dq[$];
    logic [7:0] pl[$];
    bit         rdy_pat[$];
    int         rdy_mode = 0;
    int         checks = 0, failures = 0;
    int         strobe_edge = 0;
    int         ok_cnt = 0, err_cnt = 0, last_ok_cyc = 0, last_err_cyc = 0;
    logic [1:0] last_err_code = 2'd0;
    logic [7:0] got_q[$];
    int         got_cyc[$];
    bit         got_last[$];
    logic [7:0] held_addr = 8'h00, held_len = 8'h00;
    logic [1:0] held_code = 2'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Ready driver: 0 held high, 1 random, 2 scripted while valid, 3 held low.
    initial begin
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0: rdy = 1'b1;
                1: rdy = ($urandom_range(0, 3) != 0);
                2: rdy = (o_valid && rdy_pat.size() > 0) ? rdy_pat.pop_front() : 1'b1;
                default: rdy = 1'b0;
            endcase
        end
    end

    // Compare process: every cycle, outputs against the expectation model.
    initial begin
        bit hold = 1'b0;
        logic [7:0] hd = 8'h00;
        bit hl = 1'b0;
        ev_t e;
        db_t d;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold = 1'b0; held_addr = 8'h00; held_len = 8'h00; held_code = 2'd0;
                continue;
            end
            check("ok_err_exclusive", 32'(o_ok & o_err), 0);
            if (o_ok) begin
                check("ok_pulse_expected", 32'(exp_ev.size() > 0 && exp_ev[0].is_ok), 1);
                if (exp_ev.size() > 0 && exp_ev[0].is_ok) begin
                    e = exp_ev.pop_front();
                    held_addr = e.addr; held_len = e.len;
                end
                ok_cnt++; last_ok_cyc = cyc;
            end
            if (o_err) begin
                check("err_pulse_expected", 32'(exp_ev.size() > 0 && !exp_ev[0].is_ok), 1);
                if (exp_ev.size() > 0 && !exp_ev[0].is_ok) begin
                    e = exp_ev.pop_front();
                    held_code = e.code;
                end
                err_cnt++; last_err_cyc = cyc; last_err_code = o_code;
            end
            check("addr", 32'(o_addr), 32'(held_addr));
            check("len", 32'(o_len), 32'(held_len));
            check("err_code", 32'(o_code), 32'(held_code));
            if (hold) begin
                check("hold_valid", 32'(o_valid), 1);
                check("hold_data", 32'(o_data), 32'(hd));
                check("hold_last", 32'(o_last), 32'(hl));
            end
            if (o_valid && rdy) begin
                check("data_expected", 32'(exp_dq.size() > 0), 1);
                if (exp_dq.size() > 0) begin
                    d = exp_dq.pop_front();
                    check("data", 32'(o_data), 32'(d.data));
                    check("data_last", 32'(o_last), 32'(d.last));
                end
                got_q.push_back(o_data); got_cyc.push_back(cyc); got_last.push_back(o_last);
            end
            hold = o_valid && !rdy; hd = o_data; hl = o_last;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_dv = 1'b1; rx_byte = b;
        @(posedge clk); #1;
        strobe_edge = cyc;
        rx_dv = 1'b0; rx_byte = 8'h00;
    endtask

    // Random inter-byte gap; occasionally the longest gap that must not time out.
    task automatic gap(input bit rnd);
        int r;
        if (rnd) begin
            r = $urandom_range(0, 15);
            if (r == 0) idle(T - 1); else idle(r % 4);
        end
    endtask

    function automatic logic [7:0] frame_chk(input logic [7:0] a, input logic [7:0] l);
        logic [7:0] x;
        x = a ^ l;
        foreach (pl[i]) x ^= pl[i];
        return x;
    endfunction

    task automatic expect_ok(input logic [7:0] a, input logic [7:0] l);
        ev_t e;
        db_t d;
        e.is_ok = 1'b1; e.addr = a; e.len = l; e.code = 2'd0;
        exp_ev.push_back(e);
        foreach (pl[i]) begin
            d.data = pl[i]; d.last = (i == pl.size() - 1);
            exp_dq.push_back(d);
        end
    endtask

    task automatic expect_err(input logic [1:0] c);
        ev_t e;
        e.is_ok = 1'b0; e.addr = 8'h00; e.len = 8'h00; e.code = c;
        exp_ev.push_back(e);
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] bad, input bit rnd);
        logic [7:0] l;
        l = 8'(pl.size());
        send_byte(SYNC); gap(rnd); send_byte(a); gap(rnd); send_byte(l);
        foreach (pl[i]) begin gap(rnd); send_byte(pl[i]); end
        gap(rnd);
        if (bad == 8'h00) expect_ok(a, l); else expect_err(2'd0);
        send_byte(frame_chk(a, l) ^ bad);
    endtask

    task automatic send_bad_len(input logic [7:0] a, input logic [7:0] l, input bit rnd);
        send_byte(SYNC); gap(rnd); send_byte(a); gap(rnd);
        expect_err(2'd1);
        send_byte(l);
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            if (exp_dq.size() == 0 && exp_ev.size() == 0 && !o_valid) done = 1'b1;
            else idle(1);
        end
        check("drain_within_budget", 32'(done), 1);
        if (!done) begin exp_dq.delete(); exp_ev.delete(); end
    endtask

    task automatic clear_logs();
        got_q.delete(); got_cyc.delete(); got_last.delete();
        ok_cnt = 0; err_cnt = 0;
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, 32'({o_addr, o_len, o_data, o_valid, o_last, o_ok, o_err, o_code}), 0);
    endtask

    task automatic good_123();
        pl = '{8'h01, 8'h02, 8'h03};
        send_frame(8'h12, 8'h00, 1'b0);
    endtask

    initial begin
        int se;
        int kind, stage, m;
        logic [7:0] a, b;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset_outputs");
        rst_n = 1'b1;
        idle(2);

        // Good frame, ready held high.
        clear_logs();
        pl = '{8'h01, 8'h02, 8'h03};
        check("model_chk_literal_11", 32'(frame_chk(8'h12, 8'h03)), 32'h11);
        good_123();
        se = strobe_edge;
        wait_idle();
        check("good_ok_count", ok_cnt, 1);
        check("good_ok_timing", last_ok_cyc - se, 0);
        check("good_addr_literal", 32'(o_addr), 32'h12);
        check("good_len_literal", 32'(o_len), 32'h03);
        check("good_nbytes", got_q.size(), 3);
        if (got_q.size() == 3) begin
            check("good_bytes", 32'({got_q[0], got_q[1], got_q[2]}), 32'h010203);
            check("good_first_cycle", got_cyc[0] - se, 0);
            check("good_consecutive", (got_cyc[1] - got_cyc[0]) + (got_cyc[2] - got_cyc[1]), 2);
            check("good_last_flags", 32'({got_last[0], got_last[1], got_last[2]}), 3'b001);
        end

        // Backpressure: ready 1,0,0,1,1 from the first valid cycle.
        clear_logs();
        rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        rdy_mode = 2;
        good_123();
        se = strobe_edge;
        wait_idle();
        rdy_mode = 0;
        check("bp_nbytes", got_q.size(), 3);
        if (got_q.size() == 3) begin
            check("bp_bytes", 32'({got_q[0], got_q[1], got_q[2]}), 32'h010203);
            check("bp_cycles", 32'({8'(got_cyc[0] - se), 8'(got_cyc[1] - se), 8'(got_cyc[2] - se)}), 32'h000304);
        end

        // Bad checksum (0x10), then a good frame.
        clear_logs();
        pl = '{8'h01, 8'h02, 8'h03};
        send_frame(8'h12, 8'h01, 1'b0);
        wait_idle();
        check("badchk_code", 32'(last_err_code), 0);
        check("badchk_no_data", got_q.size(), 0);
        good_123();
        wait_idle();
        check("badchk_recover", ok_cnt, 1);

        // Bad lengths 0 and MAX_LEN+1, each followed by a good frame.
        clear_logs();
        send_bad_len(8'h12, 8'h00, 1'b0);
        wait_idle();
        check("len0_code", 32'(last_err_code), 1);
        good_123();
        wait_idle();
        send_bad_len(8'h12, 8'h11, 1'b0);
        wait_idle();
        check("len17_code", 32'(last_err_code), 1);
        good_123();
        wait_idle();
        check("badlen_counts", 32'({8'(err_cnt), 8'(ok_cnt)}), 32'h0202);

        // Garbage ahead of a frame is ignored silently.
        clear_logs();
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
        good_123();
        wait_idle();
        check("garbage_counts", 32'({8'(err_cnt), 8'(ok_cnt)}), 32'h0001);

        // Timeout: decided in the cycle the timer reaches T-1, registered one edge later.
        clear_logs();
        send_byte(SYNC); send_byte(8'h12); send_byte(8'h02); send_byte(8'h07);
        se = strobe_edge;
        expect_err(2'd2);
        wait_idle();
        check("timeout_code", 32'(last_err_code), 2);
        check("timeout_latency", last_err_cyc - se, T);
        clear_logs();
        pl = '{8'h07};
        check("model_chk_literal_14", 32'(frame_chk(8'h12, 8'h01)), 32'h14);
        send_frame(8'h12, 8'h00, 1'b0);
        wait_idle();
        check("after_timeout_data", got_q.size() == 1 ? 32'(got_q[0]) : 32'hFFFF, 32'h07);

        // A byte landing on the timer's final cycle wins over the timeout.
        clear_logs();
        pl = '{8'h55};
        send_byte(SYNC); send_byte(8'h12); send_byte(8'h01);
        idle(T - 1);
        send_byte(8'h55);
        expect_ok(8'h12, 8'h01);
        send_byte(frame_chk(8'h12, 8'h01));
        wait_idle();
        check("boundary_counts", 32'({8'(err_cnt), 8'(ok_cnt)}), 32'h0001);

        // Overrun during a stalled replay.
        clear_logs();
        rdy_mode = 3;
        pl = '{8'hAA, 8'hBB};
        send_frame(8'h34, 8'h00, 1'b0);
        idle(2);
        expect_err(2'd3);
        send_byte(SYNC);
        idle(2);
        rdy_mode = 0;
        wait_idle();
        check("overrun_code", 32'(last_err_code), 3);
        check("overrun_replay", got_q.size() == 2 ? 32'({got_q[0], got_q[1]}) : 32'hFFFF, 32'hAABB);

        // Reset mid-payload: silent abandon, then a clean frame.
        clear_logs();
        send_byte(SYNC); send_byte(8'h12); send_byte(8'h03); send_byte(8'h01); send_byte(8'h02);
        rst_n = 1'b0;
        idle(1);
        check_reset_outputs("midreset_outputs");
        rst_n = 1'b1;
        idle(T + 5);
        check("midreset_no_err", err_cnt, 0);
        good_123();
        wait_idle();
        check("midreset_recover", ok_cnt, 1);

        // Randomized frames with random ready.
        rdy_mode = 1;
        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 9);
            a = 8'($urandom);
            pl.delete();
            m = $urandom_range(1, ML);
            for (int i = 0; i < m; i++) pl.push_back(8'($urandom));
            case (kind)
                5: send_frame(a, 8'($urandom_range(1, 255)), 1'b1);
                6: send_bad_len(a, ($urandom_range(0, 1) != 0) ? 8'h00 : 8'($urandom_range(ML + 1, 255)), 1'b1);
                7: begin
                    stage = $urandom_range(0, 2);
                    send_byte(SYNC);
                    if (stage >= 1) begin gap(1'b1); send_byte(a); end
                    if (stage == 2) begin
                        gap(1'b1); send_byte(8'(m));
                        for (int i = 0; i < $urandom_range(0, m); i++) begin gap(1'b1); send_byte(pl[i]); end
                    end
                    expect_err(2'd2);
                end
                8: begin
                    for (int i = 0; i < $urandom_range(1, 4); i++) begin
                        b = 8'($urandom);
                        if (b == SYNC) b = 8'h00;
                        send_byte(b);
                    end
                end
                9: begin
                    send_frame(a, 8'h00, 1'b1);
                    expect_err(2'd3);
                    send_byte(8'($urandom));
                end
                default: send_frame(a, 8'h00, 1'b1);
            endcase
            wait_idle();
        end
        rdy_mode = 0;
        idle(3);
        check("queues_empty", exp_ev.size() + exp_dq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        check("watchdog_expired", 0, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
